// File: rtl/line_clipper_pkg.sv
// Shared types, window bounds, outcode bits and FSM encodings for line_clipper.
// Also holds the outcode, edge-test, adjacency and edge-priority helpers.
package line_clipper_pkg;

  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
  } point2d_t;

  localparam logic signed [15:0] XMIN = 16'sd0;
  localparam logic signed [15:0] XMAX = 16'sd640;
  localparam logic signed [15:0] YMIN = 16'sd0;
  localparam logic signed [15:0] YMAX = 16'sd480;

  localparam logic [3:0] OC_TOP    = 4'b1000;
  localparam logic [3:0] OC_BOTTOM = 4'b0100;
  localparam logic [3:0] OC_RIGHT  = 4'b0010;
  localparam logic [3:0] OC_LEFT   = 4'b0001;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CLASSIFY = 3'd1;
  localparam logic [2:0] S_PICK     = 3'd2;
  localparam logic [2:0] S_BISECT   = 3'd3;
  localparam logic [2:0] S_OUTPUT   = 3'd4;

  function automatic logic [3:0] outcode(point2d_t p);
    logic [3:0] c;
    c = 4'b0000;
    if ($signed(p.x) < XMIN) c = c | OC_LEFT;
    if ($signed(p.x) > XMAX) c = c | OC_RIGHT;
    if ($signed(p.y) < YMIN) c = c | OC_BOTTOM;
    if ($signed(p.y) > YMAX) c = c | OC_TOP;
    return c;
  endfunction

  // True when p lies strictly outside the single edge selected by side.
  function automatic logic outside(point2d_t p, logic [3:0] side);
    logic o;
    o = 1'b0;
    unique case (1'b1)
      side[0]: o = $signed(p.x) < XMIN;
      side[1]: o = $signed(p.x) > XMAX;
      side[2]: o = $signed(p.y) < YMIN;
      side[3]: o = $signed(p.y) > YMAX;
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  function automatic logic near(logic signed [15:0] a,
                                logic signed [15:0] b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    return (d == 17'sd0) || (d == 17'sd1) || (d == -17'sd1);
  endfunction

  // Lowest set bit gives LEFT, RIGHT, BOTTOM, TOP priority.
  function automatic logic [3:0] lowbit(logic [3:0] c);
    return c & (~c + 4'd1);
  endfunction

endpackage

// File: rtl/line_clipper_if.sv
// Segment in/out valid-ready bundle for line_clipper.
// master: segment producer + sink side; slave: the clipper.
interface line_clipper_if;
  import line_clipper_pkg::*;

  logic     in_valid;
  logic     in_ready;
  point2d_t in_p0;
  point2d_t in_p1;
  logic     out_valid;
  logic     out_ready;
  point2d_t out_p0;
  point2d_t out_p1;

  modport master (
    output in_valid, in_p0, in_p1, out_ready,
    input  in_ready, out_valid, out_p0, out_p1
  );

  modport slave (
    input  in_valid, in_p0, in_p1, out_ready,
    output in_ready, out_valid, out_p0, out_p1
  );

endinterface

// File: rtl/line_clipper_bisect.sv
// Integer bisection of one segment against one window edge.
// Ports: start/side/lo_in/hi_in load a search, done pulses with hi_out valid.
module line_clipper_bisect
  import line_clipper_pkg::*;
#(
  parameter int MAX_ITER = 17
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [3:0] side_in,
  input  point2d_t   lo_in,
  input  point2d_t   hi_in,
  output logic       done,
  output point2d_t   hi_out
);

  localparam int IW = $clog2(MAX_ITER + 1);

  point2d_t        lo;
  point2d_t        hi;
  point2d_t        mid;
  logic [3:0]      side;
  logic [IW-1:0]   cnt;
  logic            run;
  logic            adj;
  logic signed [16:0] sx;
  logic signed [16:0] sy;

  // 17-bit sum then drop the LSB: arithmetic shift, floor rounding.
  always_comb begin
    sx    = {lo.x[15], lo.x} + {hi.x[15], hi.x};
    sy    = {lo.y[15], lo.y} + {hi.y[15], hi.y};
    mid.x = sx[16:1];
    mid.y = sy[16:1];
  end

  assign adj    = near(hi.x, lo.x) && near(hi.y, lo.y);
  assign done   = run && (adj || (cnt == IW'(MAX_ITER)));
  assign hi_out = hi;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      lo   <= '0;
      hi   <= '0;
      side <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      lo   <= lo_in;
      hi   <= hi_in;
      side <= side_in;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (done) begin
      run  <= 1'b0;
    end else if (run) begin
      if (outside(mid, side)) lo <= mid;
      else                    hi <= mid;
      cnt <= cnt + IW'(1);
    end
  end

endmodule

// File: rtl/line_clipper_outcode.sv
// Cohen-Sutherland outcode of one point against the screen window.
// Ports: p (point in), code (TOP/BOTTOM/RIGHT/LEFT bits out).
module line_clipper_outcode
  import line_clipper_pkg::*;
(
  input  point2d_t   p,
  output logic [3:0] code
);

  assign code = outcode(p);

endmodule

// File: rtl/line_clipper.sv
// Sequential Cohen-Sutherland clipper: drops invisible segments, clips the rest.
// Ports: clk, n_rst, bus (segment in/out handshakes), busy, acc_count, rej_count.
module line_clipper
  import line_clipper_pkg::*;
#(
  parameter int MAX_ITER = 17,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  line_clipper_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] acc_count,
  output logic [CNT_W-1:0] rej_count
);

  logic [2:0] state;
  point2d_t   p0;
  point2d_t   p1;
  logic       tgt_p1;
  logic [3:0] c0;
  logic [3:0] c1;

  logic       pick_p1;
  logic [3:0] pick_code;
  logic [3:0] pick_side;
  point2d_t   lo_in;
  point2d_t   hi_in;
  logic       bs_start;
  logic       bs_done;
  point2d_t   bs_hi;

  line_clipper_outcode u_oc0 (
    .p    (p0),
    .code (c0)
  );

  line_clipper_outcode u_oc1 (
    .p    (p1),
    .code (c1)
  );

  // Clip p0 first while it is outside; the other end is the inside anchor.
  always_comb begin
    pick_p1   = (c0 == 4'b0000);
    pick_code = pick_p1 ? c1 : c0;
    pick_side = lowbit(pick_code);
    lo_in     = pick_p1 ? p1 : p0;
    hi_in     = pick_p1 ? p0 : p1;
    bs_start  = (state == S_PICK);
  end

  line_clipper_bisect #(
    .MAX_ITER (MAX_ITER)
  ) u_bisect (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (bs_start),
    .side_in (pick_side),
    .lo_in   (lo_in),
    .hi_in   (hi_in),
    .done    (bs_done),
    .hi_out  (bs_hi)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= S_IDLE;
      p0        <= '0;
      p1        <= '0;
      tgt_p1    <= 1'b0;
      acc_count <= '0;
      rej_count <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            p0    <= bus.in_p0;
            p1    <= bus.in_p1;
            state <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          if ((c0 | c1) == 4'b0000) begin
            state <= S_OUTPUT;
          end else if ((c0 & c1) != 4'b0000) begin
            rej_count <= rej_count + CNT_W'(1);
            state     <= S_IDLE;
          end else begin
            state <= S_PICK;
          end
        end
        S_PICK: begin
          tgt_p1 <= pick_p1;
          state  <= S_BISECT;
        end
        S_BISECT: begin
          if (bs_done) begin
            if (tgt_p1) p1 <= bs_hi;
            else        p0 <= bs_hi;
            state <= S_CLASSIFY;
          end
        end
        S_OUTPUT: begin
          if (bus.out_ready) begin
            acc_count <= acc_count + CNT_W'(1);
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_OUTPUT);
  assign bus.out_p0    = p0;
  assign bus.out_p1    = p1;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_line_clipper.sv
// Scoreboard bench for line_clipper: directed segments, queued expectations.
// A negedge monitor pops and compares every emitted segment.
module tb_line_clipper;
  import line_clipper_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        busy;
  logic [15:0] acc_count;
  logic [15:0] rej_count;

  line_clipper_if bus ();

  line_clipper #(
    .MAX_ITER (17),
    .CNT_W    (16)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (bus.slave),
    .busy      (busy),
    .acc_count (acc_count),
    .rej_count (rej_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  function automatic point2d_t mk(int x, int y);
    point2d_t p;
    p.x = 16'(x);
    p.y = 16'(y);
    return p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens at the next posedge when valid&ready now.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (n_rst && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out actual=%h expected=none",
                   {bus.out_p0, bus.out_p1});
        end else begin
          e = exp_q.pop_front();
          chk("out_seg", {bus.out_p0, bus.out_p1}, e);
        end
      end
    end
  end

  // Returns just after the handshake edge T (i.e. at T+#1).
  task automatic send(point2d_t a, point2d_t b);
    int n;
    n = 0;
    bus.in_p0    = a;
    bus.in_p1    = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while (!bus.in_ready && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) chk(name, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_seg(string name, point2d_t a, point2d_t b,
                         point2d_t ea, point2d_t eb);
    exp_q.push_back({ea, eb});
    send(a, b);
    wait_idle(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_p0     = '0;
    bus.in_p1     = '0;
    bus.out_ready = 1'b1;

    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_counts", {32'd0, acc_count, rej_count}, 64'd0);
    chk("rst_out_pts", {bus.out_p0, bus.out_p1}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    // Trivial accept with exact latency
    exp_q.push_back({mk(10, 10), mk(100, 200)});
    send(mk(10, 10), mk(100, 200));
    chk("t1_classify_ov", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_t2_ov", 64'(bus.out_valid), 64'd1);
    wait_idle("t1_idle_timeout");
    chk("t1_acc", 64'(acc_count), 64'd1);

    // Trivial reject
    send(mk(-50, -10), mk(-5, 300));
    chk("t2_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    chk("t2_in_ready", 64'(bus.in_ready), 64'd1);
    chk("t2_ov", 64'(bus.out_valid), 64'd0);
    chk("t2_rej", 64'(rej_count), 64'd1);

    // Single left clip, exact
    run_seg("t3_timeout", mk(-100, 240), mk(100, 240),
            mk(0, 240), mk(100, 240));
    chk("t3_acc", 64'(acc_count), 64'd2);

    // Window corners are inside (inclusive bounds)
    run_seg("corner_timeout", mk(0, 0), mk(640, 480),
            mk(0, 0), mk(640, 480));

    // p1 only outside the top edge
    run_seg("top_timeout", mk(320, 240), mk(320, 600),
            mk(320, 240), mk(320, 480));

    // p0 outside right; endpoint order kept
    run_seg("right_timeout", mk(700, 100), mk(600, 100),
            mk(640, 100), mk(600, 100));

    // Degenerate points
    run_seg("degen_in_timeout", mk(5, 5), mk(5, 5), mk(5, 5), mk(5, 5));
    send(mk(700, 10), mk(700, 10));
    wait_idle("degen_out_timeout");
    chk("degen_rej", 64'(rej_count), 64'd2);

    // Three clips: LEFT on p0, RIGHT then TOP on p1
    exp_q.push_back({mk(0, 0), mk(480, 480)});
    send(mk(-100, -100), mk(1000, 1000));
    n = 1;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_cycles_bound", 64'(n <= 4 * (17 + 2) + 2), 64'd1);
    wait_idle("t4_idle_timeout");
    chk("t4_acc", 64'(acc_count), 64'd7);

    // Backpressure
    bus.out_ready = 1'b0;
    exp_q.push_back({mk(10, 10), mk(100, 200)});
    send(mk(10, 10), mk(100, 200));
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ov", 64'(bus.out_valid), 64'd1);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_acc", 64'(acc_count), 64'd7);
      chk("bp_pts", {bus.out_p0, bus.out_p1}, {mk(10, 10), mk(100, 200)});
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
    chk("bp_release_acc", 64'(acc_count), 64'd8);

    // Reset during bisection
    send(mk(-100, -100), mk(1000, 1000));
    repeat (4) @(posedge clk);
    #1;
    chk("rst6_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    chk("rst6_ov", 64'(bus.out_valid), 64'd0);
    chk("rst6_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst6_counts", {32'd0, acc_count, rej_count}, 64'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("rst6_after_ov", 64'(bus.out_valid), 64'd0);
    chk("rst6_after_acc", 64'(acc_count), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/line_clipper.md
Name: line_clipper

Overview:
- Sequential Cohen-Sutherland line clipper; consumes 2D segments and clips them to the screen window using outcodes.
- Sits between projection/transform and the rasteriser: clipped segments go downstream, fully invisible segments are dropped.
- Each edge intersection is found by integer bisection (adds and shifts only, no divider).

Parameters:
- MAX_ITER, 17, bisection iteration cap per edge (covers a 16-bit coordinate span).
- CNT_W, 16, width of the accept/reject statistics counters.

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- in_valid  in  1  input segment valid
- in_ready  out  1  block can accept a segment
- in_p0  in  Point2D  segment endpoint 0
- in_p1  in  Point2D  segment endpoint 1
- out_valid  out  1  clipped segment valid
- out_ready  in  1  downstream accepts the segment
- out_p0  out  Point2D  clipped endpoint 0
- out_p1  out  Point2D  clipped endpoint 1
- busy  out  1  a transaction is in flight (state != IDLE)
- acc_count  out  CNT_W  segments emitted since reset
- rej_count  out  CNT_W  segments trivially rejected since reset

Behaviour:
- One clock, clk; reset n_rst is asynchronous, active-low.
- Reset clears everything: state IDLE, in_ready=1, out_valid=0, out_p0/out_p1=0, busy=0, counters=0.
- Reset mid-transaction discards the segment; nothing is emitted.
- Point2D: x and y are signed 16-bit. The window is inclusive: 0<=x<=640, 0<=y<=480.
- Outcode bits are TOP=8, BOTTOM=4, RIGHT=2, LEFT=1.
- in_ready = (state==IDLE). out_valid = (state==OUTPUT).
- States:
  - IDLE: on in_valid, register p0/p1 and go to CLASSIFY.
  - CLASSIFY: compute c0, c1 from the registered points.
    - c0|c1==0: go to OUTPUT.
    - c0&c1!=0: increment rej_count, go to IDLE.
    - otherwise: go to PICK.
  - PICK: target is p0 if c0!=0, else p1. Edge priority is LEFT, RIGHT, BOTTOM, TOP (first set bit of the target code).
    - lo=target, hi=other endpoint. hi is guaranteed inside that edge because the segment was not trivially rejected.
    - Go to BISECT.
  - BISECT: one iteration per cycle.
    - mid = (lo+hi)>>>1 per coordinate, using a 17-bit signed sum and arithmetic shift (floor).
    - If mid is outside the selected edge, lo=mid; otherwise hi=mid.
    - Terminate when |hi.x-lo.x|<=1 and |hi.y-lo.y|<=1, or after MAX_ITER iterations.
    - On termination: target=hi, go to CLASSIFY.
    - The clipped coordinate lands exactly on the boundary; the other coordinate is within ±1 LSB of the exact intersection.
  - OUTPUT: out_p0/out_p1 hold the clipped points and stay stable until out_ready.
    - On out_valid&out_ready: increment acc_count, go to IDLE.
- Endpoint order is preserved: p0 stays p0, p1 stays p1.
- Termination: at most 4 edge clips per segment (2 per endpoint), so worst case is about 4*(MAX_ITER+2)+2 cycles.
- Latency:
  - Segment handshaked at edge T: CLASSIFY during T+1; trivial accept gives out_valid from T+2.
  - Trivial reject gives in_ready=1 again from T+2.
- Counters wrap modulo 2^CNT_W and are never saturated.
- in_valid while busy is ignored (in_ready=0). in_p0/in_p1 are don't-care unless in_valid&in_ready.
- Degenerate segment p0==p1 is handled by CLASSIFY only: accepted if inside, rejected if outside.

Decomposition:
- defines_package holds:
  - Point2D;
  - window constants XMIN=0, XMAX=640, YMIN=0, YMAX=480;
  - outcode bit constants;
  - clip state enum.
- Two instances of the existing outcode module give c0/c1 from the working endpoints.
- A single edge-test function (point outside a given edge) is shared by PICK and BISECT.
- One sub-module is natural: clip_bisect, holding the lo/hi registers, midpoint arithmetic, the adjacency test and the iteration counter. It has a start/done handshake with the FSM.

Test Plan:
- (10,10)-(100,200) handshaked at T -> out_valid at T+2 with an identical segment; acc_count=1.
- (-50,-10)-(-5,300) -> out_valid never asserts; rej_count=1; in_ready high again at T+2.
- (-100,240)-(100,240) -> out (0,240)-(100,240) exactly.
- (-100,-100)-(1000,1000) -> LEFT clip on p0, RIGHT then TOP clip on p1 -> out (0,0)-(480,480); each bisection takes <=17 cycles.
- Backpressure on test 1 with out_ready low for 5 cycles -> out_p0/out_p1 stable, in_ready=0, acc_count unchanged until out_ready rises; then IDLE next cycle.
- Test 4 with n_rst pulsed low during BISECT -> out_valid=0 immediately; after release in_ready=1, counters=0; no segment emitted.
